// File: rtl/approx_arb_pkg.sv
// Shared types and the round-robin pick helper for the approximate-adder arbiter.
// Pure declarations: no latency or backpressure of its own.
package approx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // The pick helper works on a fixed 8-wide vector; narrower arbiters zero-pad.
  localparam int MAX_REQ = 8;
  localparam int PICK_W  = $clog2(MAX_REQ);

  // First set bit of valid[0..n-1] at or after ptr, wrapping; 0 when none is set.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PICK_W-1:0]  ptr,
    input int                 n
  );
    logic [PICK_W-1:0] pick;
    logic [PICK_W:0]   idx;
    pick = '0;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PICK_W + 1)'(k);
      if (idx >= (PICK_W + 1)'(n)) begin
        idx = idx - (PICK_W + 1)'(n);
      end
      if ((k < n) && valid[idx[PICK_W-1:0]]) begin
        pick = idx[PICK_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: one-hot grant plus index of the first valid at or after ptr.
// Purely combinational; the caller owns the pointer and decides when a grant counts.
module rr_arbiter
  import approx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [PICK_W-1:0]  pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    pick                     = rr_pick(valid_ext, PICK_W'(ptr), NUM_REQ);
    any                      = |valid;
    idx                      = ID_W'(pick);
    grant                    = '0;
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/approx_adder_arbiter.sv
// Shares one external approximate adder among NUM_REQ requesters, round-robin, with an exact-sum error counter.
// Accept to rsp_valid is 2 cycles; one op per 3 cycles at best; RESP holds under rsp_ready=0 and blocks new grants.
module approx_adder_arbiter
  import approx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ERR_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]           add_in1,
  output logic [WIDTH-1:0]           add_in2,
  input  logic [WIDTH:0]             add_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH:0]             rsp_sum,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_err,
  output logic [ERR_W-1:0]           err_cnt,
  input  logic                       err_clr
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t               state;
  state_t               state_nxt;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_any;
  logic [NUM_REQ-1:0]   gnt_vec;
  logic [WIDTH-1:0]     a_arr [NUM_REQ];
  logic [WIDTH-1:0]     b_arr [NUM_REQ];
  logic [WIDTH:0]       exact_sum;
  logic                 calc_err;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .any   (gnt_any),
    .grant (gnt_vec),
    .idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are only visible in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    if (rst_n && (state == IDLE)) begin
      req_ready = gnt_vec;
    end
    if (state == RESP) begin
      rsp_valid = 1'b1;
    end
  end

  // The adder sees the operand registers for the whole CALC cycle.
  always_comb begin
    exact_sum = {1'b0, add_in1} + {1'b0, add_in2};
    calc_err  = (add_out != exact_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      add_in1 <= '0;
      add_in2 <= '0;
      rsp_sum <= '0;
      rsp_id  <= '0;
      rsp_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if ((state == IDLE) && gnt_any) begin
        add_in1 <= a_arr[gnt_idx];
        add_in2 <= b_arr[gnt_idx];
        rsp_id  <= gnt_idx;
        rr_ptr  <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == CALC) begin
        rsp_sum <= add_out;
        rsp_err <= calc_err;
      end
      if (err_clr) begin
        err_cnt <= '0;
      end else if ((state == CALC) && calc_err && !(&err_cnt)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_arbiter.sv
// Bench for approx_adder_arbiter: directed scenarios plus random traffic against a cycle-timeline transaction model.
// The adder stand-in drops the bit-0 carry (bit 0 = IN2[0]) and adds the upper bits exactly.
module tb_approx_adder_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int EW = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [W-1:0]     add_in1;
  logic [W-1:0]     add_in2;
  logic [W:0]       add_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W:0]       rsp_sum;
  logic [IW-1:0]    rsp_id;
  logic             rsp_err;
  logic [EW-1:0]    err_cnt;
  logic             err_clr;

  always #5 clk = ~clk;

  assign add_out = {({1'b0, add_in1[W-1:1]} + {1'b0, add_in2[W-1:1]}), add_in2[0]};

  approx_adder_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W),
    .ERR_W   (EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .add_out   (add_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Transaction model: cycle index, pointer, one outstanding response and the counter.
  int cyc      = 0;
  int m_ptr    = 0;
  bit pend     = 0;
  int p_due    = 0;
  int p_id     = 0;
  int p_sum    = 0;
  bit p_err    = 0;
  int inc_cyc  = -1;
  int m_cnt    = 0;
  int grant_ok = 0;
  int last_gnt = -1;

  function automatic int approx(input int a, input int b);
    return (a / 2 + b / 2) * 2 + b % 2;
  endfunction

  // Checks the current cycle against the model, advances the model, then steps one clock.
  task automatic tick();
    int w;
    int a;
    int b;
    bit exp_v;
    logic [N-1:0] exp_rdy;
    #1;
    w = -1;
    if (rst_n && (cyc >= grant_ok)) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if ((w < 0) && req_valid[j]) w = j;
      end
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_v = pend && (cyc >= p_due);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check("rsp_sum", 32'(rsp_sum), 32'(p_sum));
      check("rsp_id", 32'(rsp_id), 32'(p_id));
      check("rsp_err", 32'(rsp_err), 32'(p_err));
    end
    check("err_cnt", 32'(err_cnt), 32'(m_cnt));
    last_gnt = w;
    if (!rst_n) begin
      m_ptr    = 0;
      pend     = 0;
      m_cnt    = 0;
      inc_cyc  = -1;
      grant_ok = cyc + 1;
    end else begin
      if (err_clr) m_cnt = 0;
      else if ((cyc == inc_cyc) && p_err && (m_cnt < (1 << EW) - 1)) m_cnt++;
      if (exp_v && rsp_ready) begin
        pend     = 0;
        grant_ok = cyc + 1;
      end
      if (w >= 0) begin
        a        = int'(req_a[w*W +: W]);
        b        = int'(req_b[w*W +: W]);
        pend     = 1;
        p_due    = cyc + 2;
        p_id     = w;
        p_sum    = approx(a, b);
        p_err    = (p_sum != a + b);
        inc_cyc  = cyc + 1;
        m_ptr    = (w + 1) % N;
        grant_ok = 1 << 30;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic op(input int id, input int a, input int b, input int exp_sum,
                    input int exp_err, input int exp_cnt, input string tag);
    req_valid              = '0;
    req_valid[id]          = 1'b1;
    req_a[id*W +: W]       = W'(a);
    req_b[id*W +: W]       = W'(b);
    rsp_ready              = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    tick();
    req_valid = '0;
    tick();
    #1;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    tick();
  endtask

  bit       rv [N];
  logic [W-1:0] ra [N];
  logic [W-1:0] rb [N];

  initial begin
    int gcyc[$];
    int gid[$];
    int a;
    int b;

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_add_in1", 32'(add_in1), 32'd0);
    check("rst_add_in2", 32'(add_in2), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = '1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    // Plain add, then lost-carry mismatches.
    op(0, 2, 4, 6, 0, 0, "t1");
    op(1, 1, 1, 1, 1, 1, "t2a");
    op(1, 255, 255, 509, 1, 2, "t2b");

    // All requesters held valid: grants rotate 0,1,2,3,0 three cycles apart.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'($urandom_range(0, 255));
      req_b[i*W +: W] = W'($urandom_range(0, 255));
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      #1;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          gcyc.push_back(cyc);
          gid.push_back(i);
        end
      end
      tick();
    end
    req_valid = '0;
    check("t3_ngrants", 32'(gid.size()), 32'd5);
    for (int k = 0; k < gid.size() && k < 5; k++) begin
      check("t3_order", 32'(gid[k]), 32'(k % N));
      if (k > 0) check("t3_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
    end

    // Backpressure holds the response and blocks new grants.
    req_a[2*W +: W] = 8'd3;
    req_b[2*W +: W] = 8'd5;
    req_valid       = 4'b0100;
    rsp_ready       = 1'b0;
    tick();
    req_valid = 4'b1011;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_valid", 32'(rsp_valid), 32'd1);
      check("t4_sum", 32'(rsp_sum), 32'd7);
      check("t4_id", 32'(rsp_id), 32'd2);
      check("t4_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;

    // Saturation at 15, then clear racing a mismatching CALC edge.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a = 2 * $urandom_range(0, 127) + 1;
      b = 2 * $urandom_range(0, 127) + 1;
      op(k % N, a, b, approx(a, b), 1, (k + 1 > 15) ? 15 : k + 1, "t5sat");
    end
    req_valid       = 4'b0010;
    req_a[1*W +: W] = 8'd1;
    req_b[1*W +: W] = 8'd1;
    tick();
    req_valid = '0;
    err_clr   = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("t5_clr_cnt", 32'(err_cnt), 32'd0);
    check("t5_clr_err", 32'(rsp_err), 32'd1);
    tick();

    // Reset during CALC drops the operation and rewinds the pointer.
    op(3, 3, 3, 5, 1, 1, "t6pre");
    req_valid       = 4'b1000;
    req_a[3*W +: W] = 8'd1;
    req_b[3*W +: W] = 8'd1;
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_valid", 32'(rsp_valid), 32'd0);
    check("t6_cnt", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t6_noresp", 32'(rsp_valid), 32'd0);
      tick();
    end
    req_valid = '1;
    #1;
    check("t6_ptr", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    tick();
    tick();

    // Random traffic with backpressure, clears and occasional resets.
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rv[i] && (last_gnt == i)) rv[i] = 1'b0;
        if (!rv[i] && ($urandom_range(0, 2) == 0)) begin
          rv[i] = 1'b1;
          ra[i] = W'($urandom_range(0, 255));
          rb[i] = W'($urandom_range(0, 255));
        end else if (rv[i] && ($urandom_range(0, 49) == 0)) begin
          rv[i] = 1'b0;
        end
        req_valid[i]    = rv[i];
        req_a[i*W +: W] = ra[i];
        req_b[i*W +: W] = rb[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 99) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
